// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive and transmit paths.
// Holds word/byte widths, the receiver FSM encoding and default link timing.
package uart_pkg;

  localparam int NB_BYTE        = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int NB_DATA        = NB_BYTE * BYTES_PER_WORD;

  localparam int CLK_FREQ_HZ    = 25_000_000;
  localparam int BAUD_RATE      = 9600;

  // About five byte times at the default baud rate and clock.
  localparam int DEFAULT_TIMEOUT_CYCLES = 130208;
  localparam int DEFAULT_NB_TIMEOUT     = 18;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte watchdog: counts clocks while running and flags the clock on which
// TIMEOUT_CYCLES idle clocks have elapsed since the last restart.
module rx_timeout_counter #(
  parameter int TIMEOUT_CYCLES = uart_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int NB_TIMEOUT     = uart_pkg::DEFAULT_NB_TIMEOUT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_restart,
  input  logic i_run,
  output logic o_expired
);

  localparam logic [NB_TIMEOUT-1:0] LAST_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] cnt_q;
  logic [NB_TIMEOUT-1:0] cnt_d;

  // A restart in the expiry cycle suppresses the expiry: the new byte wins.
  assign o_expired = i_run && !i_restart && (cnt_q == LAST_COUNT);

  always_comb begin
    cnt_d = cnt_q + NB_TIMEOUT'(1);
    if (i_restart || !i_run || o_expired) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/word_receiver.sv
// Packs four received UART bytes into one word and offers it on a valid/ready port.
// Partial words are dropped after an inter-byte timeout; lost complete words set overrun.
module word_receiver #(
  parameter int NB_DATA        = uart_pkg::NB_DATA,
  parameter int NB_BYTE        = uart_pkg::NB_BYTE,
  parameter int TIMEOUT_CYCLES = uart_pkg::DEFAULT_TIMEOUT_CYCLES,
  parameter int NB_TIMEOUT     = uart_pkg::DEFAULT_NB_TIMEOUT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_clear,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_valid,
  output logic [1:0]         o_byte_count,
  output logic               o_timeout,
  output logic               o_overrun,
  output logic               o_dbg_state
);

  import uart_pkg::*;

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  rx_state_e             state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0]    shift_q, shift_d;
  logic [NB_DATA-1:0]    word_q, word_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;
  logic                  overrun_q, overrun_d;
  logic                  expired;
  logic [NB_DATA-1:0]    shifted;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .NB_TIMEOUT     (NB_TIMEOUT)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_restart (i_rx_done),
    .i_run     (state_q == ST_COLLECT),
    .o_expired (expired)
  );

  // Newest byte enters at the top, so after four bytes the first sits in [7:0].
  assign shifted = {i_rx_data, shift_q[NB_DATA-1:NB_BYTE]};

  // Handshake: o_word is transferred in any cycle with o_valid=1 and i_ready=1;
  // o_valid then drops on the next edge unless a new word completes in that same cycle.
  // While o_valid=1 and i_ready=0, o_word is held and a newly completed word is lost.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    timeout_d  = 1'b0;
    if (i_clear) begin
      state_d    = ST_IDLE;
      byte_cnt_d = '0;
      shift_d    = '0;
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      if (valid_q && i_ready) begin
        valid_d = 1'b0;
      end
      if (i_rx_done) begin
        shift_d = shifted;
        if (byte_cnt_q == LAST_BYTE) begin
          state_d    = ST_IDLE;
          byte_cnt_d = '0;
          if (!valid_q || i_ready) begin
            word_d  = shifted;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          state_d    = ST_COLLECT;
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end else if (expired) begin
        state_d    = ST_IDLE;
        byte_cnt_d = '0;
        shift_d    = '0;
        timeout_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_word       = word_q;
  assign o_valid      = valid_q;
  assign o_byte_count = byte_cnt_q;
  assign o_timeout    = timeout_q;
  assign o_overrun    = overrun_q;
  assign o_dbg_state  = logic'(state_q);

endmodule

// File: tb/tb_word_receiver.sv
// Bench for word_receiver: directed scenarios plus random traffic, every cycle
// compared against a byte-queue reference model of the receiver.
module tb_word_receiver;

  localparam int TO  = 20;
  localparam int NBT = 5;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_done  = 1'b0;
  logic        clear    = 1'b0;
  logic        ready    = 1'b0;
  logic [31:0] o_word;
  logic        o_valid;
  logic [1:0]  o_byte_count;
  logic        o_timeout;
  logic        o_overrun;
  logic        o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic [31:0] m_word;
  logic        m_valid;
  logic        m_overrun;
  logic        m_timeout;

  word_receiver #(
    .NB_DATA        (32),
    .NB_BYTE        (8),
    .TIMEOUT_CYCLES (TO),
    .NB_TIMEOUT     (NBT)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_clear      (clear),
    .i_ready      (ready),
    .o_word       (o_word),
    .o_valid      (o_valid),
    .o_byte_count (o_byte_count),
    .o_timeout    (o_timeout),
    .o_overrun    (o_overrun),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_bytes.delete();
    m_idle    = 0;
    m_word    = 32'h0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_timeout = 1'b0;
  endtask

  task automatic m_step();
    logic old_valid;
    m_timeout = 1'b0;
    if (clear) begin
      m_bytes.delete();
      m_idle    = 0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end else begin
      old_valid = m_valid;
      if (m_valid && ready) m_valid = 1'b0;
      if (rx_done) begin
        m_bytes.push_back(rx_data);
        m_idle = 0;
        if (m_bytes.size() == 4) begin
          if (old_valid && !ready) begin
            m_overrun = 1'b1;
          end else begin
            m_word  = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_valid = 1'b1;
          end
          m_bytes.delete();
        end
      end else if (m_bytes.size() != 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_bytes.delete();
          m_idle    = 0;
          m_timeout = 1'b1;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("valid",      32'(o_valid),      32'(m_valid));
    check("byte_count", 32'(o_byte_count), 32'(m_bytes.size()));
    check("timeout",    32'(o_timeout),    32'(m_timeout));
    check("overrun",    32'(o_overrun),    32'(m_overrun));
    check("dbg_state",  32'(o_dbg_state),  32'(m_bytes.size() != 0));
    if (m_valid) check("word", o_word, m_word);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; inputs are held across the next edge, then outputs compared.
  task automatic drive_cycle(input logic done, input logic [7:0] data,
                             input logic rdy, input logic clr);
    rx_done = done;
    rx_data = data;
    ready   = rdy;
    clear   = clr;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] data, input logic rdy);
    drive_cycle(1'b1, data, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check("rst_word",    o_word,              32'h0);
    check("rst_valid",   32'(o_valid),        32'd0);
    check("rst_count",   32'(o_byte_count),   32'd0);
    check("rst_timeout", 32'(o_timeout),      32'd0);
    check("rst_overrun", 32'(o_overrun),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single word, consumer ready
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_word",  o_word,       32'h44332211);
    idle(1, 1'b1);
    check("t1_drop",  32'(o_valid), 32'd0);

    // 2: overrun with consumer stalled, then clear
    for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
    check("t2_word",    o_word,         32'hA3A2A1A0);
    check("t2_overrun", 32'(o_overrun), 32'd1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t2_clr_valid",   32'(o_valid),   32'd0);
    check("t2_clr_overrun", 32'(o_overrun), 32'd0);

    // 3: timeout after two bytes, then a clean word
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle(TO - 1, 1'b1);
    check("t3_pre_timeout", 32'(o_timeout),    32'd0);
    check("t3_pre_count",   32'(o_byte_count), 32'd2);
    idle(1, 1'b1);
    check("t3_timeout", 32'(o_timeout),    32'd1);
    check("t3_count",   32'(o_byte_count), 32'd0);
    idle(1, 1'b1);
    check("t3_pulse_end", 32'(o_timeout), 32'd0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    check("t3_word", o_word, 32'h04030201);
    idle(1, 1'b1);

    // 4: third byte lands exactly on the expiry cycle
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    idle(TO - 1, 1'b1);
    send_byte(8'h77, 1'b1);
    check("t4_timeout", 32'(o_timeout),    32'd0);
    check("t4_count",   32'(o_byte_count), 32'd3);
    send_byte(8'h88, 1'b1);
    check("t4_word", o_word, 32'h88776655);
    idle(1, 1'b1);

    // 5: asynchronous reset mid-word with a word pending
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b0);
    send_byte(8'hD0, 1'b0);
    send_byte(8'hD1, 1'b0);
    rx_done = 1'b0;
    ready   = 1'b0;
    rst_n   = 1'b0;
    #3;
    check("t5_word",    o_word,            32'h0);
    check("t5_valid",   32'(o_valid),      32'd0);
    check("t5_count",   32'(o_byte_count), 32'd0);
    check("t5_overrun", 32'(o_overrun),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), 1'b1);
    check("t5_clean_word", o_word, 32'hE3E2E1E0);
    idle(1, 1'b1);

    // 6: completion coincides with acceptance
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i), 1'b0);
    send_byte(8'h23, 1'b1);
    check("t6_valid",   32'(o_valid),   32'd1);
    check("t6_word",    o_word,         32'h23222120);
    check("t6_overrun", 32'(o_overrun), 32'd0);
    idle(1, 1'b1);

    // random traffic, including gaps at and around the timeout boundary
    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 30) == 0) begin
        idle(TO - 2 + int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end else begin
        drive_cycle(1'($urandom_range(0, 2) == 0), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 60) == 0));
      end
    end
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
